// File: rtl/shared_arith_scheduler.sv
// Round-robin scheduler sharing one ADD / iterative shift-add MUL unit
// between N requesters; one transaction in flight, tagged response.
module shared_arith_scheduler #(
  parameter int N = 4,
  parameter int W = 10
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst,
  input  logic [N-1:0]                          i_req_valid,
  output logic [N-1:0]                          o_req_ready,
  input  logic [N-1:0]                          i_req_op,
  input  logic [N*W-1:0]                        i_req_a,
  input  logic [N*W-1:0]                        i_req_b,
  output logic                                  o_resp_valid,
  input  logic                                  i_resp_ready,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0]  o_resp_id,
  output logic [W-1:0]                          o_resp_data,
  output logic                                  o_resp_ovf,
  output logic                                  o_busy
);

  localparam int IDW = (N > 1) ? $clog2(N) : 1;
  localparam int CW  = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_RESP
  } state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   rr_q, rr_d;
  logic [IDW-1:0]   id_q, id_d;
  logic             op_q, op_d;
  logic [2*W-1:0]   mcand_q, mcand_d;
  logic [W-1:0]     mplier_q, mplier_d;
  logic [2*W-1:0]   acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             rvalid_q, rvalid_d;
  logic [IDW-1:0]   rid_q, rid_d;
  logic [W-1:0]     rdata_q, rdata_d;
  logic             rovf_q, rovf_d;

  logic             gnt_found;
  logic [IDW-1:0]   gnt_idx;
  logic [W:0]       sum_c;
  logic [2*W-1:0]   acc_nx;

  // First valid requester at or after rr_q, wrapping.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int i = 0; i < N; i++) begin
      if (!gnt_found && i_req_valid[(int'(rr_q) + i) % N]) begin
        gnt_found = 1'b1;
        gnt_idx   = IDW'((int'(rr_q) + i) % N);
      end
    end
  end

  always_comb begin
    o_req_ready = '0;
    if (state_q == S_IDLE && gnt_found && !i_rst)
      o_req_ready = N'(1) << gnt_idx;
  end

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    id_d     = id_q;
    op_d     = op_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    rvalid_d = rvalid_q;
    rid_d    = rid_q;
    rdata_d  = rdata_q;
    rovf_d   = rovf_q;
    sum_c    = {1'b0, mcand_q[W-1:0]} + {1'b0, mplier_q};
    acc_nx   = acc_q + (mplier_q[0] ? mcand_q : '0);
    unique case (state_q)
      S_IDLE: begin
        if (gnt_found) begin
          op_d     = i_req_op[gnt_idx];
          mcand_d  = {{W{1'b0}}, i_req_a[int'(gnt_idx)*W +: W]};
          mplier_d = i_req_b[int'(gnt_idx)*W +: W];
          acc_d    = '0;
          cnt_d    = '0;
          id_d     = gnt_idx;
          rr_d     = IDW'((int'(gnt_idx) + 1) % N);
          state_d  = S_EXEC;
        end
      end
      S_EXEC: begin
        if (!op_q) begin
          rdata_d  = sum_c[W-1:0];
          rovf_d   = sum_c[W];
          rid_d    = id_q;
          rvalid_d = 1'b1;
          state_d  = S_RESP;
        end else begin
          acc_d    = acc_nx;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == CW'(W - 1)) begin
            rdata_d  = acc_nx[W-1:0];
            rovf_d   = |acc_nx[2*W-1:W];
            rid_d    = id_q;
            rvalid_d = 1'b1;
            state_d  = S_RESP;
          end
        end
      end
      S_RESP: begin
        if (i_resp_ready) begin
          rvalid_d = 1'b0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      rr_q     <= '0;
      id_q     <= '0;
      op_q     <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      rvalid_q <= 1'b0;
      rid_q    <= '0;
      rdata_q  <= '0;
      rovf_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      id_q     <= id_d;
      op_q     <= op_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
      rid_q    <= rid_d;
      rdata_q  <= rdata_d;
      rovf_q   <= rovf_d;
    end
  end

  assign o_resp_valid = rvalid_q;
  assign o_resp_id    = rid_q;
  assign o_resp_data  = rdata_q;
  assign o_resp_ovf   = rovf_q;
  assign o_busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_shared_arith_scheduler.sv
// Scoreboard bench for shared_arith_scheduler: expected results are
// queued at grant and compared while the response is presented.
module tb_shared_arith_scheduler;

  localparam int N = 4;
  localparam int W = 10;

  logic         i_clk = 1'b0;
  logic         i_rst;
  logic [N-1:0] v;
  logic [N-1:0] op;
  logic [W-1:0] a [N];
  logic [W-1:0] b [N];
  logic         i_resp_ready;

  logic [N-1:0]   o_req_ready;
  logic [N*W-1:0] i_req_a;
  logic [N*W-1:0] i_req_b;
  logic           o_resp_valid;
  logic [1:0]     o_resp_id;
  logic [W-1:0]   o_resp_data;
  logic           o_resp_ovf;
  logic           o_busy;

  assign i_req_a = {a[3], a[2], a[1], a[0]};
  assign i_req_b = {b[3], b[2], b[1], b[0]};

  shared_arith_scheduler #(.N(N), .W(W)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_req_valid  (v),
    .o_req_ready  (o_req_ready),
    .i_req_op     (op),
    .i_req_a      (i_req_a),
    .i_req_b      (i_req_b),
    .o_resp_valid (o_resp_valid),
    .i_resp_ready (i_resp_ready),
    .o_resp_id    (o_resp_id),
    .o_resp_data  (o_resp_data),
    .o_resp_ovf   (o_resp_ovf),
    .o_busy       (o_busy)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int id;
    int data;
    int ovf;
    int t;
    int lat;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   rr_m = 0;
  int   last_gnt;
  bit   prev_valid = 0;
  bit   seen3 = 0;

  task automatic check(string tag, longint got, longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  function automatic int exp_grant();
    for (int i = 0; i < N; i++)
      if (v[(rr_m + i) % N]) return (rr_m + i) % N;
    return -1;
  endfunction

  function automatic exp_t model(int k);
    exp_t e;
    logic [2*W-1:0] p;
    logic [W:0] s;
    e.id = k;
    e.t = cyc + 1;
    if (op[k]) begin
      p = {{W{1'b0}}, a[k]} * {{W{1'b0}}, b[k]};
      e.data = int'(p[W-1:0]);
      e.ovf = int'(|p[2*W-1:W]);
      e.lat = W;
    end else begin
      s = {1'b0, a[k]} + {1'b0, b[k]};
      e.data = int'(s[W-1:0]);
      e.ovf = int'(s[W]);
      e.lat = 1;
    end
    return e;
  endfunction

  task automatic step();
    int g;
    exp_t e;
    last_gnt = -1;
    @(negedge i_clk);
    if (o_req_ready != '0) begin
      g = exp_grant();
      check("gnt_busy", longint'(o_busy), 0);
      check("gnt_onehot", $countones(o_req_ready), 1);
      check("gnt_vec", longint'(o_req_ready), (g < 0) ? 0 : (1 << g));
      for (int i = 0; i < N; i++)
        if (o_req_ready[i]) last_gnt = i;
      if (o_req_ready[3]) seen3 = 1;
      if (g >= 0) begin
        q.push_back(model(g));
        rr_m = (g + 1) % N;
      end
    end
    if (o_resp_valid) begin
      if (q.size() == 0) begin
        check("spurious_resp", 1, 0);
      end else begin
        e = q[0];
        if (!prev_valid) check("latency", cyc - e.t, e.lat);
        check("resp_id", longint'(o_resp_id), e.id);
        check("resp_data", longint'(o_resp_data), e.data);
        check("resp_ovf", longint'(o_resp_ovf), e.ovf);
        if (i_resp_ready) void'(q.pop_front());
      end
    end
    prev_valid = o_resp_valid;
    @(posedge i_clk);
    cyc++;
    #1;
  endtask

  task automatic wait_grant(int k);
    for (int i = 0; i < 100; i++) begin
      step();
      if (last_gnt == k) return;
    end
    check("gnt_timeout", 0, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      if (q.size() == 0 && !o_resp_valid) return;
      step();
    end
    check("drain_timeout", q.size(), 0);
    q.delete();
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    step();
    step();
    q.delete();
    rr_m = 0;
    prev_valid = 0;
    i_rst = 1'b0;
  endtask

  task automatic set_req(int k, bit o, int x, int y);
    op[k] = o;
    a[k] = W'(x);
    b[k] = W'(y);
    v[k] = 1'b1;
  endtask

  initial begin
    int n;
    i_rst = 1'b1;
    v = '0;
    op = '0;
    for (int k = 0; k < N; k++) begin
      a[k] = '0;
      b[k] = '0;
    end
    i_resp_ready = 1'b1;
    step();
    v = '1;
    step();
    check("rst_valid", longint'(o_resp_valid), 0);
    check("rst_id", longint'(o_resp_id), 0);
    check("rst_data", longint'(o_resp_data), 0);
    check("rst_ovf", longint'(o_resp_ovf), 0);
    check("rst_busy", longint'(o_busy), 0);
    check("rst_ready", longint'(o_req_ready), 0);
    v = '0;
    i_rst = 1'b0;
    step();

    // ADD with overflow from requester 2
    set_req(2, 0, 1000, 30);
    wait_grant(2);
    v[2] = 1'b0;
    drain();

    // two MULs from requester 0
    set_req(0, 1, 31, 33);
    wait_grant(0);
    v[0] = 1'b0;
    drain();
    set_req(0, 1, 32, 32);
    wait_grant(0);
    v[0] = 1'b0;
    drain();
    check("last_data_held", longint'(o_resp_data), 0);
    check("last_ovf_held", longint'(o_resp_ovf), 1);

    // fairness with all requesters continuously valid
    do_reset();
    set_req(0, 0, 500, 600);
    set_req(1, 0, 300, 200);
    set_req(2, 0, 900, 124);
    set_req(3, 0, 77, 1);
    n = 0;
    for (int i = 0; i < 200 && n < 6; i++) begin
      step();
      if (last_gnt >= 0) begin
        check("rr_order", last_gnt, n % N);
        n++;
      end
    end
    check("rr_count", n, 6);
    v = '0;
    drain();

    // held response while requester 3 waits
    do_reset();
    i_resp_ready = 1'b0;
    set_req(1, 1, 5, 7);
    set_req(3, 0, 12, 34);
    wait_grant(1);
    v[1] = 1'b0;
    for (int i = 0; i < 50 && !o_resp_valid; i++) step();
    check("hold_valid", longint'(o_resp_valid), 1);
    for (int i = 0; i < 5; i++) step();
    i_resp_ready = 1'b1;
    wait_grant(3);
    v[3] = 1'b0;
    drain();

    // asynchronous reset during MUL iteration 4
    do_reset();
    set_req(0, 1, 123, 456);
    wait_grant(0);
    v[0] = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("pre_rst_busy", longint'(o_busy), 1);
    #2;
    i_rst = 1'b1;
    #1;
    check("arst_busy", longint'(o_busy), 0);
    check("arst_valid", longint'(o_resp_valid), 0);
    q.delete();
    rr_m = 0;
    prev_valid = 0;
    step();
    step();
    i_rst = 1'b0;
    set_req(1, 0, 1, 2);
    set_req(0, 0, 3, 4);
    wait_grant(0);
    v[0] = 1'b0;
    wait_grant(1);
    v[1] = 1'b0;
    drain();

    // requester 3 withdraws before it could be granted
    do_reset();
    seen3 = 0;
    i_resp_ready = 1'b0;
    set_req(0, 0, 10, 20);
    wait_grant(0);
    v[0] = 1'b0;
    set_req(3, 0, 5, 5);
    set_req(1, 0, 40, 50);
    for (int i = 0; i < 50 && !o_resp_valid; i++) step();
    step();
    v[3] = 1'b0;
    step();
    i_resp_ready = 1'b1;
    wait_grant(1);
    v[1] = 1'b0;
    drain();
    for (int i = 0; i < 5; i++) step();
    check("no_grant3", seen3, 0);
    check("queue_empty", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
